// File: rtl/mac_op_sequencer_pkg.sv
// Shared types for the MAC operand sequencer: MAC mode encodings,
// sequencer state enum and the lanes-per-step lookup.
package mac_op_sequencer_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE = 3'd0,
    MODE_INT2 = 3'd1,
    MODE_INT4 = 3'd2,
    MODE_INT8 = 3'd3,
    MODE_BF16 = 3'd4,
    MODE_FP16 = 3'd5,
    MODE_TF32 = 3'd6,
    MODE_FP32 = 3'd7
  } mode_caculation;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_MIXED  = 1'b1
  } mode_precision;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  // Elements packed into one 32-bit operand step; 0 marks a mode the
  // sequencer cannot issue.
  function automatic logic [3:0] lanes_per_step(input mode_caculation m);
    case (m)
      MODE_INT4:            return 4'd8;
      MODE_INT8:            return 4'd4;
      MODE_BF16, MODE_FP16: return 4'd2;
      MODE_TF32, MODE_FP32: return 4'd1;
      default:              return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mac_step_calc.sv
// Combinational step planner: from a mode and K length derive the
// number of 32-bit steps, full-step lane count, tail lane count and
// whether the command must be rejected. Requires KW >= 3.
module mac_step_calc
  import mac_op_sequencer_pkg::*;
#(
  parameter int KW = 16
) (
  input  logic [2:0]    i_mode,
  input  logic [KW-1:0] i_k_len,
  output logic [KW-1:0] o_steps,
  output logic [3:0]    o_lanes,
  output logic [3:0]    o_tail_lanes,
  output logic          o_illegal
);

  logic [3:0]  w_lanes;
  logic [2:0]  w_round;
  logic [1:0]  w_shamt;
  logic [KW:0] w_sum;
  logic [KW:0] w_q;
  logic [2:0]  w_rem;

  // Lanes are powers of two, so ceil-divide is add-then-shift; the extra
  // sum bit keeps k_len = 2^KW-1 from wrapping.
  always_comb begin
    w_lanes = lanes_per_step(mode_caculation'(i_mode));
    w_round = '0;
    w_shamt = '0;
    case (w_lanes)
      4'd8:    begin w_round = 3'd7; w_shamt = 2'd3; end
      4'd4:    begin w_round = 3'd3; w_shamt = 2'd2; end
      4'd2:    begin w_round = 3'd1; w_shamt = 2'd1; end
      default: begin w_round = 3'd0; w_shamt = 2'd0; end
    endcase
    w_sum        = {1'b0, i_k_len} + {{(KW-2){1'b0}}, w_round};
    w_q          = w_sum >> w_shamt;
    o_steps      = w_q[KW-1:0];
    w_rem        = i_k_len[2:0] & w_round;
    o_lanes      = w_lanes;
    o_tail_lanes = (w_rem == 3'd0) ? w_lanes : {1'b0, w_rem};
    o_illegal    = (w_lanes == 4'd0) || (i_k_len == '0);
  end

endmodule

// File: rtl/mac_op_sequencer.sv
// Command-driven sequencer for the shared MAC pipeline: accepts one
// dot-product command, programs the MAC mode, issues tagged operand
// steps, waits MAC_LAT cycles for the pipeline to drain, pulses done.
// Optional performance counters are built when MAC_SEQ_PERF_EN is defined.
module mac_op_sequencer
  import mac_op_sequencer_pkg::*;
#(
  parameter int MAC_LAT = 4,
  parameter int KW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_mode,
  input  logic          cmd_prec,
  input  logic [KW-1:0] cmd_k_len,
  output logic          cmd_err,
  output logic [2:0]    mac_mode,
  output logic          mac_prec,
  output logic          issue_valid,
  input  logic          op_ready,
  output logic          issue_first,
  output logic          issue_last,
  output logic [3:0]    issue_lanes,
  output logic          busy,
  output logic          done
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_busy_cyc,
  output logic [31:0]   perf_stall_cyc,
  input  logic          perf_clr
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(MAC_LAT - 1);

  seq_state_e     r_state;
  logic           r_err;
  mode_caculation r_mode;
  mode_precision  r_prec;
  logic [KW-1:0]  r_idx;
  logic [KW-1:0]  r_last_idx;
  logic [3:0]     r_lanes;
  logic [3:0]     r_tail;
  logic [3:0]     r_cnt;
  logic           r_valid;
  logic           r_first;
  logic           r_last;
  logic [3:0]     r_issue_lanes;

  logic [KW-1:0]  w_steps;
  logic [3:0]     w_lanes;
  logic [3:0]     w_tail;
  logic           w_illegal;
  logic [KW-1:0]  w_idx_nxt;

  mac_step_calc #(.KW(KW)) u_step_calc (
    .i_mode       (cmd_mode),
    .i_k_len      (cmd_k_len),
    .o_steps      (w_steps),
    .o_lanes      (w_lanes),
    .o_tail_lanes (w_tail),
    .o_illegal    (w_illegal)
  );

  assign w_idx_nxt = r_idx + KW'(1);

  // Command acceptance, step issue and drain countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_err         <= 1'b0;
      r_mode        <= MODE_IDLE;
      r_prec        <= MODE_NORMAL;
      r_idx         <= '0;
      r_last_idx    <= '0;
      r_lanes       <= '0;
      r_tail        <= '0;
      r_cnt         <= '0;
      r_valid       <= 1'b0;
      r_first       <= 1'b0;
      r_last        <= 1'b0;
      r_issue_lanes <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_state       <= ISSUE;
              r_mode        <= mode_caculation'(cmd_mode);
              r_prec        <= mode_precision'(cmd_prec);
              r_idx         <= '0;
              r_last_idx    <= w_steps - KW'(1);
              r_lanes       <= w_lanes;
              r_tail        <= w_tail;
              r_valid       <= 1'b1;
              r_first       <= 1'b1;
              r_last        <= (w_steps == KW'(1));
              r_issue_lanes <= (w_steps == KW'(1)) ? w_tail : w_lanes;
            end
          end
        end
        ISSUE: begin
          if (op_ready) begin
            if (r_last) begin
              r_state       <= WAIT;
              r_cnt         <= LAT_M1;
              r_valid       <= 1'b0;
              r_first       <= 1'b0;
              r_last        <= 1'b0;
              r_issue_lanes <= '0;
            end else begin
              r_idx         <= w_idx_nxt;
              r_first       <= 1'b0;
              r_last        <= (w_idx_nxt == r_last_idx);
              r_issue_lanes <= (w_idx_nxt == r_last_idx) ? r_tail : r_lanes;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == WAIT) && (r_cnt == '0);
  assign cmd_err     = r_err;
  assign mac_mode    = r_mode;
  assign mac_prec    = r_prec;
  assign issue_valid = r_valid;
  assign issue_first = r_first;
  assign issue_last  = r_last;
  assign issue_lanes = r_issue_lanes;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  // Saturating busy/stall cycle counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (busy && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == ISSUE) && !op_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_cyc  = r_perf_busy;
  assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_mac_op_sequencer.sv
// Self-checking bench for mac_op_sequencer: directed and randomized
// commands compared against a step-list reference model.
module tb_mac_op_sequencer;
  import mac_op_sequencer_pkg::*;

  localparam int MAC_LAT = 4;
  localparam int KW      = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_mode;
  logic          cmd_prec;
  logic [KW-1:0] cmd_k_len;
  logic          cmd_err;
  logic [2:0]    mac_mode;
  logic          mac_prec;
  logic          issue_valid;
  logic          op_ready;
  logic          issue_first;
  logic          issue_last;
  logic [3:0]    issue_lanes;
  logic          busy;
  logic          done;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0]   perf_busy_cyc;
  logic [31:0]   perf_stall_cyc;
  logic          perf_clr;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mac_op_sequencer #(.MAC_LAT(MAC_LAT), .KW(KW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_prec    (cmd_prec),
    .cmd_k_len   (cmd_k_len),
    .cmd_err     (cmd_err),
    .mac_mode    (mac_mode),
    .mac_prec    (mac_prec),
    .issue_valid (issue_valid),
    .op_ready    (op_ready),
    .issue_first (issue_first),
    .issue_last  (issue_last),
    .issue_lanes (issue_lanes),
    .busy        (busy),
    .done        (done)
`ifdef MAC_SEQ_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_clr       (perf_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference lane count per 32-bit word for each mode.
  function automatic int ref_lanes(input int m);
    case (m)
      2:       return 8;
      3:       return 4;
      4, 5:    return 2;
      6, 7:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"},   cmd_ready,   1);
    chk({tag, "_cmd_err"},     cmd_err,     0);
    chk({tag, "_mac_mode"},    mac_mode,    MODE_IDLE);
    chk({tag, "_mac_prec"},    mac_prec,    MODE_NORMAL);
    chk({tag, "_issue_valid"}, issue_valid, 0);
    chk({tag, "_issue_first"}, issue_first, 0);
    chk({tag, "_issue_last"},  issue_last,  0);
    chk({tag, "_issue_lanes"}, issue_lanes, 0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_done"},        done,        0);
`ifdef MAC_SEQ_PERF_EN
    chk({tag, "_perf_busy"},   perf_busy_cyc,  0);
    chk({tag, "_perf_stall"},  perf_stall_cyc, 0);
`endif
  endtask

  // One full command: accept, walk the expected step list, then count the drain.
  task automatic run_cmd(input int m, input int p, input int k,
                         input int stall_idx, input int stall_n, input bit rnd,
                         input bit chain, input int nm, input int nk,
                         output int busy_cyc, output int stall_cyc);
    int q[$];
    int rem, ln, idx, budget, stalls;
    ln = ref_lanes(m);
    rem = k;
    while (rem > 0) begin
      q.push_back((rem > ln) ? ln : rem);
      rem -= ln;
    end
    busy_cyc = 0;
    stall_cyc = 0;
    chk("pre_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = 3'(m);
    cmd_prec  = 1'(p);
    cmd_k_len = KW'(k);
    tick();
    cmd_valid = 1'b0;
    chk("acc_mac_mode",  mac_mode,  m);
    chk("acc_mac_prec",  mac_prec,  p);
    chk("acc_busy",      busy,      1);
    chk("acc_cmd_ready", cmd_ready, 0);
    idx = 0;
    budget = 0;
    stalls = 0;
    while (idx < q.size() && budget < q.size() + 100) begin
      chk("iss_valid", issue_valid, 1);
      chk("iss_first", issue_first, (idx == 0) ? 1 : 0);
      chk("iss_last",  issue_last,  (idx == q.size() - 1) ? 1 : 0);
      chk("iss_lanes", issue_lanes, q[idx]);
      chk("iss_done",  done,        0);
      if (rnd) op_ready = ($urandom_range(0, 3) != 0);
      else if (idx == stall_idx && stalls < stall_n) begin
        op_ready = 1'b0;
        stalls++;
      end else op_ready = 1'b1;
      tick();
      busy_cyc++;
      budget++;
      if (op_ready) idx++;
      else stall_cyc++;
    end
    chk("steps_transferred", idx, q.size());
    op_ready = 1'b1;
    if (chain) begin
      cmd_valid = 1'b1;
      cmd_mode  = 3'(nm);
      cmd_prec  = 1'b0;
      cmd_k_len = KW'(nk);
    end
    for (int c = 1; c <= MAC_LAT; c++) begin
      chk("wait_done",      done,        (c == MAC_LAT) ? 1 : 0);
      chk("wait_valid",     issue_valid, 0);
      chk("wait_cmd_ready", cmd_ready,   0);
      chk("wait_mac_mode",  mac_mode,    m);
      tick();
      busy_cyc++;
    end
    chk("post_done",      done,      0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_busy",      busy,      0);
    chk("post_mac_mode",  mac_mode,  m);
    chk("post_mac_prec",  mac_prec,  p);
  endtask

  task automatic err_cmd(input int m, input int k);
    logic [2:0] prev;
    prev = mac_mode;
    cmd_valid = 1'b1;
    cmd_mode  = 3'(m);
    cmd_prec  = 1'b0;
    cmd_k_len = KW'(k);
    tick();
    cmd_valid = 1'b0;
    chk("err_pulse",     cmd_err,     1);
    chk("err_valid",     issue_valid, 0);
    chk("err_cmd_ready", cmd_ready,   1);
    chk("err_busy",      busy,        0);
    chk("err_mac_mode",  mac_mode,    prev);
    tick();
    chk("err_clear",     cmd_err,     0);
    chk("err_valid2",    issue_valid, 0);
    chk("err_busy2",     busy,        0);
  endtask

  initial begin
    int bc, sc, m, k;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = '0;
    cmd_prec  = 1'b0;
    cmd_k_len = '0;
    op_ready  = 1'b1;
`ifdef MAC_SEQ_PERF_EN
    perf_clr  = 1'b0;
`endif
    tick();
    tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();
    chk_reset_vals("rst_rel");

    // FP32, 3 single-lane steps
    run_cmd(MODE_FP32, 0, 3, -1, 0, 1'b0, 1'b0, 0, 0, bc, sc);

    // INT4, lanes 8 then 2; mode persists in IDLE
    run_cmd(MODE_INT4, 1, 10, -1, 0, 1'b0, 1'b0, 0, 0, bc, sc);
    tick();
    tick();
    chk("int4_mode_persist", mac_mode, 3'b010);

    // rejected commands
    err_cmd(MODE_INT2, 5);
    err_cmd(MODE_FP16, 0);
    err_cmd(MODE_IDLE, 7);
    chk("err_mode_kept", mac_mode, 3'b010);

`ifdef MAC_SEQ_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_busy",  perf_busy_cyc,  0);
    chk("perf_clr_stall", perf_stall_cyc, 0);
`endif
    // FP16 with 3 stall cycles on step 1
    run_cmd(MODE_FP16, 0, 5, 1, 3, 1'b0, 1'b0, 0, 0, bc, sc);
    chk("stall_issue_cycles", bc, 3 + 3 + MAC_LAT);
`ifdef MAC_SEQ_PERF_EN
    chk("perf_stall_3",   perf_stall_cyc, 3);
    chk("perf_busy_cnt",  perf_busy_cyc,  bc);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr2_busy",  perf_busy_cyc,  0);
    chk("perf_clr2_stall", perf_stall_cyc, 0);
`endif

    // BF16 then INT8 presented during WAIT
    run_cmd(MODE_BF16, 1, 3, -1, 0, 1'b0, 1'b1, MODE_INT8, 6, bc, sc);
    run_cmd(MODE_INT8, 0, 6, -1, 0, 1'b0, 1'b0, 0, 0, bc, sc);

    // reset during step 1 of INT8 k=16
    cmd_valid = 1'b1;
    cmd_mode  = MODE_INT8;
    cmd_prec  = 1'b1;
    cmd_k_len = KW'(16);
    op_ready  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("abort_s0_first", issue_first, 1);
    chk("abort_s0_lanes", issue_lanes, 4);
    tick();
    chk("abort_s1_valid", issue_valid, 1);
    chk("abort_s1_first", issue_first, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("abort");
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done",  done,        0);
      chk("abort_no_issue", issue_valid, 0);
      tick();
    end

    // single-step command: first and last together
    run_cmd(MODE_TF32, 0, 1, -1, 0, 1'b0, 1'b0, 0, 0, bc, sc);
    run_cmd(MODE_INT4, 0, 8, -1, 0, 1'b0, 1'b0, 0, 0, bc, sc);

    // randomized commands with random back-pressure
    for (int i = 0; i < 10; i++) begin
      m = $urandom_range(2, 7);
      k = $urandom_range(1, 40);
      run_cmd(m, $urandom_range(0, 1), k, -1, 0, 1'b1, 1'b0, 0, 0, bc, sc);
    end

    // maximum K length must not overflow the step computation
    run_cmd(MODE_INT4, 0, 65535, -1, 0, 1'b0, 1'b0, 0, 0, bc, sc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_op_sequencer.md
Name: mac_op_sequencer

Overview:
Command-driven sequencer for the shared MAC pipeline.
- Accepts one dot-product command per handshake: precision mode, mixed/normal flag and K length.
- Sets the MAC's static mode configuration, issues packed 32-bit operand steps with first/last/lane-count tags, and waits for the MAC pipeline to drain.
- Signals completion with a done pulse.
- Sits between the tile controller and the MAC array/operand buffer.

Parameters:
MAC_LAT, 4, MAC pipeline depth in cycles from an accepted issue to its result; legal range 1..15.
KW, 16, width of the K-length field.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  sequencer can accept a command
cmd_mode  in  3  pkg::mode_caculation
cmd_prec  in  1  pkg::mode_precision
cmd_k_len  in  KW  number of K elements
cmd_err  out  1  one-cycle pulse: command rejected
mac_mode  out  3  static MAC mode configuration, held for the whole command
mac_prec  out  1  static MAC precision configuration
issue_valid  out  1  operand step valid
op_ready  in  1  operand buffer/MAC accepts the step
issue_first  out  1  first step of the command (clear accumulator)
issue_last  out  1  final step of the command
issue_lanes  out  4  valid lanes in this 32-bit step (1..8)
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse: command's result has left the MAC

Behaviour:
- Reset values: state IDLE, cmd_ready=1, cmd_err=0, mac_mode=MODE_IDLE, mac_prec=MODE_NORMAL, issue_*=0, busy=0, done=0, all counters 0.
- Reset asserted mid-operation aborts immediately. The next cycle shows reset values with no done pulse.
- Lanes per step:
  - INT4: 8
  - INT8: 4
  - BF16, FP16: 2
  - TF32, FP32: 1
- steps = ceil(k_len/lanes).
- Every step except the last carries issue_lanes=lanes.
- The last step carries issue_lanes = k_len − (steps−1)·lanes.
- States:
  - IDLE: cmd_ready=1. On cmd_valid:
    - If cmd_mode is MODE_IDLE or MODE_INT2, or k_len==0: cmd_err pulses the next cycle, no other change, stay in IDLE.
    - Otherwise: latch mode, prec and steps; set mac_mode/mac_prec on the next edge; go to ISSUE.
  - ISSUE: issue_valid=1 registered, first asserted the cycle after acceptance.
    - A step transfers when issue_valid && op_ready.
    - While op_ready=0, all issue_* outputs hold stable.
    - issue_first=1 only on step 0.
    - issue_last=1 only on step steps−1; both are set when steps==1.
    - On transfer of the last step, go to WAIT.
  - WAIT: cmd_ready=0, issue_valid=0, down-counter loaded with MAC_LAT−1.
    - When the counter reaches 0: done=1 for that one cycle, go to IDLE.
    - done therefore occurs exactly MAC_LAT cycles after the last-step transfer cycle.
- cmd_ready is 0 in ISSUE and WAIT. A mode change can therefore only reach the MAC once the pipeline is empty.
- mac_mode/mac_prec persist after done until the next accepted command.
- The step counter is KW bits wide; k_len = 2^KW−1 must not overflow.

Optional Feature:
MAC_SEQ_PERF_EN
- With the macro defined, extra ports are present:
  - perf_busy_cyc out 32: cycles with busy=1, saturating at 2^32−1.
  - perf_stall_cyc out 32: cycles in ISSUE with op_ready=0, saturating at 2^32−1.
  - perf_clr in 1: synchronous clear of both counters, taking priority over increment.
- Both counters reset to 0 on rst.
- Without the macro: no ports, no counter flops; behaviour is otherwise identical.

Decomposition:
- Shared package pkg holds:
  - mode_caculation and mode_precision (existing).
  - A new seq_state_e enum: IDLE, ISSUE, WAIT.
  - A lanes_per_step(mode_caculation) function returning 4'd1/2/4/8, with 0 for illegal modes.
- One sub-module: mac_step_calc, combinational. Takes mode and k_len; outputs steps, tail_lanes and an illegal flag.
- Everything else lives in the top FSM.

Test Plan:
- FP32, k_len=3, op_ready=1 → 3 steps, lanes 1/1/1; first on step 0, last on step 2; done 4 cycles after step 2 (MAC_LAT=4).
- INT4, k_len=10 → 2 steps, lanes 8 then 2; mac_mode=3'b010 from the cycle after acceptance until the next command.
- cmd_mode=MODE_INT2, then a separate command with k_len=0 → each produces one cmd_err pulse, no issue_valid, state stays IDLE.
- FP16, k_len=5, op_ready low for 3 cycles on step 1 → step 1 outputs held stable (lanes=2, first=0); total 3 steps with lanes 2/2/1; done timing shifts by 3 cycles.
- BF16 command followed by an INT8 command presented during WAIT → cmd_ready=0 until after done; INT8 mac_mode appears only after done.
- rst pulsed during ISSUE step 1 of INT8 k_len=16 → all outputs at reset values the next cycle, no done.
- With MAC_SEQ_PERF_EN: the stall test above → perf_stall_cyc=3; perf_clr → both counters read 0 the next cycle.
